// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and FSM states for the memory-access stage
package cpu_pkg;

  localparam logic [2:0] DM_RD_NONE = 3'd0;
  localparam logic [2:0] DM_RD_LB   = 3'd1;
  localparam logic [2:0] DM_RD_LBU  = 3'd2;
  localparam logic [2:0] DM_RD_LH   = 3'd3;
  localparam logic [2:0] DM_RD_LHU  = 3'd4;
  localparam logic [2:0] DM_RD_LW   = 3'd5;
  localparam logic [2:0] DM_RD_LWU  = 3'd6;
  localparam logic [2:0] DM_RD_LD   = 3'd7;

  localparam logic [2:0] DM_WR_NONE = 3'd0;
  localparam logic [2:0] DM_WR_SB   = 3'd1;
  localparam logic [2:0] DM_WR_SH   = 3'd2;
  localparam logic [2:0] DM_WR_SW   = 3'd3;
  localparam logic [2:0] DM_WR_SD   = 3'd4;

  localparam logic [1:0] RF_WR_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_WR_SEL_MEM = 2'd1;
  localparam logic [1:0] RF_WR_SEL_PC4 = 2'd2;
  localparam logic [1:0] RF_WR_SEL_IMM = 2'd3;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } mem_state_t;

  // log2 of the access size in bytes; a store encoding takes priority
  function automatic logic [1:0] access_size(input logic [2:0] rd_ctrl,
                                             input logic [2:0] wr_ctrl);
    logic [1:0] sz;
    if (wr_ctrl != DM_WR_NONE) begin
      case (wr_ctrl)
        DM_WR_SB: sz = 2'd0;
        DM_WR_SH: sz = 2'd1;
        DM_WR_SW: sz = 2'd2;
        default:  sz = 2'd3;
      endcase
    end else begin
      case (rd_ctrl)
        DM_RD_LB, DM_RD_LBU: sz = 2'd0;
        DM_RD_LH, DM_RD_LHU: sz = 2'd1;
        DM_RD_LW, DM_RD_LWU: sz = 2'd2;
        default:             sz = 2'd3;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, strobes, load extension and access checks
module mem_lane_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        addr_lo,
  input  logic [2:0]        rd_ctrl,
  input  logic [2:0]        wr_ctrl,
  input  logic [XLEN-1:0]   st_data,
  input  logic [XLEN-1:0]   ld_word,
  output logic [XLEN-1:0]   st_wdata,
  output logic [XLEN/8-1:0] st_wstrb,
  output logic [XLEN-1:0]   ld_data,
  output logic              is_mem,
  output logic              is_store,
  output logic              bad
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = (XLEN == 64) ? 3 : 2;

  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_size;
  logic [7:0]        w_strb8;
  logic [STRB_W-1:0] w_size_strb;
  logic [XLEN-1:0]   w_size_mask;
  logic [XLEN-1:0]   w_shift_ld;
  logic              w_illegal;
  logic              w_misalign;

  assign w_off = addr_lo[OFF_W-1:0];

  always_comb begin
    w_size     = access_size(rd_ctrl, wr_ctrl);
    is_store   = (wr_ctrl != DM_WR_NONE);
    is_mem     = is_store || (rd_ctrl != DM_RD_NONE);
    w_illegal  = (wr_ctrl > DM_WR_SD) || (is_store && (rd_ctrl != DM_RD_NONE));
    // the 32-bit datapath has no doubleword or zero-extended word accesses
    if (XLEN == 32) begin
      w_illegal = w_illegal || (rd_ctrl == DM_RD_LWU) || (rd_ctrl == DM_RD_LD) ||
                  (wr_ctrl == DM_WR_SD);
    end
    case (w_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = addr_lo[0];
      2'd2:    w_misalign = (addr_lo[1:0] != 2'b00);
      default: w_misalign = (addr_lo != 3'b000);
    endcase
    bad = is_mem && (w_illegal || w_misalign);
  end

  always_comb begin
    case (w_size)
      2'd0:    w_strb8 = 8'h01;
      2'd1:    w_strb8 = 8'h03;
      2'd2:    w_strb8 = 8'h0F;
      default: w_strb8 = 8'hFF;
    endcase
    w_size_strb = w_strb8[STRB_W-1:0];
    w_size_mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_size_mask[8*i +: 8] = {8{w_size_strb[i]}};
    end
    st_wdata = (st_data & w_size_mask) << {w_off, 3'b000};
    st_wstrb = is_store ? (w_size_strb << w_off) : '0;
  end

  always_comb begin
    w_shift_ld = ld_word >> {w_off, 3'b000};
    case (rd_ctrl)
      DM_RD_LB:  ld_data = XLEN'($signed(w_shift_ld[7:0]));
      DM_RD_LBU: ld_data = XLEN'(w_shift_ld[7:0]);
      DM_RD_LH:  ld_data = XLEN'($signed(w_shift_ld[15:0]));
      DM_RD_LHU: ld_data = XLEN'(w_shift_ld[15:0]);
      DM_RD_LW:  ld_data = XLEN'($signed(w_shift_ld[31:0]));
      DM_RD_LWU: ld_data = XLEN'(w_shift_ld[31:0]);
      default:   ld_data = w_shift_ld;
    endcase
  end

endmodule

// File: rtl/pipeline_mem_stage_hs.sv
// rtl/pipeline_mem_stage_hs.sv - handshaked memory-access stage between EX and WB
module pipeline_mem_stage_hs
  import cpu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result_ex,
  input  logic [XLEN-1:0]   reg_data2_ex,
  input  logic [4:0]        rd_ex,
  input  logic [XLEN-1:0]   pc_ex,
  input  logic [2:0]        dm_rd_ctrl_ex,
  input  logic [2:0]        dm_wr_ctrl_ex,
  input  logic              rf_wr_en_ex,
  input  logic [1:0]        rf_wr_sel_ex,
  output logic              dm_req_valid,
  input  logic              dm_req_ready,
  output logic              dm_req_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN/8-1:0] dm_wstrb,
  input  logic              dm_rsp_valid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   pc_mem,
  output logic [XLEN-1:0]   alu_result_mem,
  output logic [XLEN-1:0]   mem_data_mem,
  output logic [4:0]        rd_mem,
  output logic              rf_wr_en_mem,
  output logic [1:0]        rf_wr_sel_mem,
  output logic              misalign_mem
);

  localparam int STRB_W = XLEN / 8;

  mem_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_we;
  logic [2:0]        r_rd_ctrl;
  logic [2:0]        r_off;
  logic              r_kill;
  logic [XLEN-1:0]   r_p_pc, r_p_alu;
  logic [4:0]        r_p_rd;
  logic              r_p_rf_wr_en;
  logic [1:0]        r_p_rf_wr_sel;
  logic              r_wb_valid;
  logic [XLEN-1:0]   r_pc, r_alu, r_mem_data;
  logic [4:0]        r_rd;
  logic              r_rf_wr_en;
  logic [1:0]        r_rf_wr_sel;
  logic              r_misalign;

  logic              w_idle, w_take, w_accept, w_rsp, w_commit;
  logic [2:0]        w_sel_rd, w_sel_wr, w_sel_off;
  logic [XLEN-1:0]   w_wdata, w_ld_data;
  logic [STRB_W-1:0] w_wstrb;
  logic              w_is_mem, w_is_store, w_bad;
  logic [ADDR_W-1:0] w_addr_ex;

  assign w_idle   = (r_state == MEM_IDLE);
  assign w_take   = w_idle && in_valid && !flush;
  assign w_accept = (r_state == MEM_REQ) && dm_req_ready;
  assign w_rsp    = (r_state == MEM_WAIT) && dm_rsp_valid;
  assign w_commit = (w_accept && r_we && !flush) || (w_rsp && !r_kill && !flush);

  // one aligner: fed from EX while idle (decode, store lanes), from captured state afterwards (load)
  assign w_sel_rd  = w_idle ? dm_rd_ctrl_ex : r_rd_ctrl;
  assign w_sel_wr  = w_idle ? dm_wr_ctrl_ex : DM_WR_NONE;
  assign w_sel_off = w_idle ? alu_result_ex[2:0] : r_off;
  assign w_addr_ex = ADDR_W'(alu_result_ex) & ~ADDR_W'(STRB_W - 1);

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .addr_lo  (w_sel_off),
    .rd_ctrl  (w_sel_rd),
    .wr_ctrl  (w_sel_wr),
    .st_data  (reg_data2_ex),
    .ld_word  (dm_rdata),
    .st_wdata (w_wdata),
    .st_wstrb (w_wstrb),
    .ld_data  (w_ld_data),
    .is_mem   (w_is_mem),
    .is_store (w_is_store),
    .bad      (w_bad)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MEM_IDLE: if (w_take && w_is_mem && !w_bad) w_state_nxt = MEM_REQ;
      MEM_REQ: begin
        if (dm_req_ready)  w_state_nxt = r_we ? MEM_IDLE : MEM_WAIT;
        else if (flush)    w_state_nxt = MEM_IDLE;
      end
      MEM_WAIT: if (dm_rsp_valid) w_state_nxt = MEM_IDLE;
      default:  w_state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= MEM_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_we          <= 1'b0;
      r_rd_ctrl     <= DM_RD_NONE;
      r_off         <= 3'd0;
      r_kill        <= 1'b0;
      r_p_pc        <= '0;
      r_p_alu       <= '0;
      r_p_rd        <= 5'd0;
      r_p_rf_wr_en  <= 1'b0;
      r_p_rf_wr_sel <= 2'd0;
      r_wb_valid    <= 1'b0;
      r_pc          <= '0;
      r_alu         <= '0;
      r_mem_data    <= '0;
      r_rd          <= 5'd0;
      r_rf_wr_en    <= 1'b0;
      r_rf_wr_sel   <= 2'd0;
      r_misalign    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= 1'b0;
      if (w_take) begin
        if (!w_is_mem || w_bad) begin
          r_wb_valid  <= 1'b1;
          r_pc        <= pc_ex;
          r_alu       <= alu_result_ex;
          r_mem_data  <= '0;
          r_rd        <= rd_ex;
          r_rf_wr_en  <= rf_wr_en_ex && !w_bad;
          r_rf_wr_sel <= rf_wr_sel_ex;
          r_misalign  <= w_bad;
        end else begin
          r_addr        <= w_addr_ex;
          r_wdata       <= w_wdata;
          r_wstrb       <= w_wstrb;
          r_we          <= w_is_store;
          r_rd_ctrl     <= dm_rd_ctrl_ex;
          r_off         <= alu_result_ex[2:0];
          r_kill        <= 1'b0;
          r_p_pc        <= pc_ex;
          r_p_alu       <= alu_result_ex;
          r_p_rd        <= rd_ex;
          r_p_rf_wr_en  <= rf_wr_en_ex;
          r_p_rf_wr_sel <= rf_wr_sel_ex;
        end
      end
      // a flushed load still has to drain its response before the stage frees up
      if (flush && ((w_accept && !r_we) || (r_state == MEM_WAIT))) r_kill <= 1'b1;
      if (w_commit) begin
        r_wb_valid  <= 1'b1;
        r_pc        <= r_p_pc;
        r_alu       <= r_p_alu;
        r_mem_data  <= r_we ? '0 : w_ld_data;
        r_rd        <= r_p_rd;
        r_rf_wr_en  <= r_p_rf_wr_en;
        r_rf_wr_sel <= r_p_rf_wr_sel;
        r_misalign  <= 1'b0;
      end
    end
  end

  assign in_ready       = w_idle;
  assign dm_req_valid   = (r_state == MEM_REQ);
  assign dm_req_we      = r_we;
  assign dm_addr        = r_addr;
  assign dm_wdata       = r_wdata;
  assign dm_wstrb       = r_wstrb;
  assign wb_valid       = r_wb_valid;
  assign pc_mem         = r_pc;
  assign alu_result_mem = r_alu;
  assign mem_data_mem   = r_mem_data;
  assign rd_mem         = r_rd;
  assign rf_wr_en_mem   = r_rf_wr_en;
  assign rf_wr_sel_mem  = r_rf_wr_sel;
  assign misalign_mem   = r_misalign;

endmodule

// File: doc/pipeline_mem_stage_hs.md
Name: pipeline_mem_stage_hs

Overview:
Parametrised successor of the 5-stage CPU memory-access stage. Takes one EX-stage instruction per cycle. Loads and stores go through a valid/ready request, response-valid data-memory handshake, and the stage stalls EX while a memory transaction is outstanding. Adds byte-lane steering, write strobes, load sign/zero extension, misalignment detection and flush. Sits between EX and WB.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
ADDR_W, 64, data-memory address width.
STRB_W, XLEN/8, write-strobe width (derived, not overridden).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
flush  in  1  kill the instruction in this stage (branch/trap)
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage can accept; low stalls EX
alu_result_ex  in  XLEN  effective address or ALU result
reg_data2_ex  in  XLEN  store data
rd_ex  in  5  destination register
pc_ex  in  XLEN  instruction PC
dm_rd_ctrl_ex  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD
dm_wr_ctrl_ex  in  3  0 none, 1 SB, 2 SH, 3 SW, 4 SD, 5-7 illegal
rf_wr_en_ex  in  1  register write enable
rf_wr_sel_ex  in  2  WB mux select, passed through
dm_req_valid  out  1  memory request valid
dm_req_ready  in  1  memory accepts request
dm_req_we  out  1  1 store, 0 load
dm_addr  out  ADDR_W  address aligned down to XLEN/8 bytes
dm_wdata  out  XLEN  store data shifted to its byte lanes
dm_wstrb  out  STRB_W  byte enables; all zero for loads
dm_rsp_valid  in  1  load data valid
dm_rdata  in  XLEN  full-word load data
wb_valid  out  1  one-cycle pulse: WB outputs valid
pc_mem, alu_result_mem, mem_data_mem  out  XLEN  to WB; mem_data_mem is extended load data
rd_mem  out  5  to WB
rf_wr_en_mem  out  1  gated write enable
rf_wr_sel_mem  out  2  to WB
misalign_mem  out  1  address misaligned or illegal access; valid with wb_valid

Behaviour:
- Reset (asynchronous, reset=0): FSM to IDLE. All outputs 0, except in_ready=1 once in IDLE.
- FSM states:
  - IDLE: in_ready=1.
  - REQ: dm_req_valid=1, driven from the captured registers.
  - WAIT: waiting for dm_rsp_valid.
- Capture (edge with in_valid & in_ready & !flush):
  - Non-memory op, or illegal/misaligned access: write WB outputs directly, wb_valid=1 next cycle, stay IDLE. Throughput is one per cycle.
  - Memory op: capture into internal registers and go to REQ.
- Misaligned access:
  - Halfword needs addr[0]=0; word needs addr[1:0]=0; doubleword needs addr[2:0]=0.
  - When XLEN=32, LWU, LD and SD are illegal.
  - Illegal or misaligned: no memory request; misalign_mem=1; rf_wr_en_mem=0.
- REQ:
  - Request accepted (dm_req_ready=1): a store goes to IDLE and pulses wb_valid next cycle; a load goes to WAIT.
  - Not accepted: all dm_* outputs hold stable.
- WAIT:
  - On dm_rsp_valid, register mem_data_mem and go to IDLE; wb_valid pulses next cycle.
  - Load-to-WB latency is 1 cycle after the response.
  - dm_rsp_valid outside WAIT is ignored.
- Load extension: select the byte/half/word at addr offset, then sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU) to XLEN.
- Store steering: dm_wdata is the store data replicated/shifted to the lane at addr offset; dm_wstrb bits are set for the accessed bytes only. Examples: SB @offset 5 gives 8'b0010_0000; SD gives 8'hFF.
- Flush:
  - In IDLE: suppresses capture.
  - In REQ before acceptance: drop dm_req_valid and go to IDLE with no wb_valid.
  - In WAIT: set a kill flag, consume the response, go to IDLE with no wb_valid.
  - Flush on the same edge as acceptance in REQ: a store is already committed and still produces no wb_valid; a load follows the WAIT kill path.
- wb_valid=0 cycles: WB payload holds its last value; WB must qualify on wb_valid.
- Reset mid-transaction: abandon immediately; the memory side must also be reset.

Decomposition:
- Shared package (cpu_pkg) holds:
  - rd/wr control encodings (DM_RD_*, DM_WR_*);
  - FSM state typedef (MEM_IDLE, MEM_REQ, MEM_WAIT);
  - rf_wr_sel encodings.
- One sub-module: mem_lane_align. It is combinational and parametrised by XLEN. It computes store lane shift plus strobe, load extract plus extend, and the misalign/illegal flag. The stage instantiates it once for the store path and uses its load function on dm_rdata.

Test Plan:
- ALU op, alu_result_ex=0x1234, rd=5, in_valid for 4 back-to-back cycles -> wb_valid every cycle, no dm_req_valid, alu_result_mem=0x1234.
- LB @0x1003, dm_rdata=0x00000000_80000000, ready=1, response 1 cycle later -> dm_addr=0x1000, mem_data_mem=0xFFFF_FFFF_FFFF_FF80; LBU of the same -> 0x80.
- SH @0x2006, data=0xBEEF, dm_req_ready low for 3 cycles -> dm_* stable and in_ready=0 for 3 cycles; dm_wstrb=8'hC0, dm_wdata[63:48]=0xBEEF; wb_valid 1 cycle after acceptance.
- LW @0x3002 -> no request, misalign_mem=1, rf_wr_en_mem=0, wb_valid next cycle. XLEN=32 build, LD -> misalign_mem=1.
- LD issued, flush asserted in WAIT, response arrives 2 cycles later -> no wb_valid; next instruction accepted the cycle after the response.
- reset pulled low while in REQ -> dm_req_valid=0 immediately, all outputs 0; after release, in_ready=1.
